// File: rtl/add_sub_pkg.sv
// Shared definitions for the Level-02 ALU 16-bit adder/subtractor.
// Holds the datapath width, operation-select encodings and the word type.
package add_sub_pkg;

    localparam int ADD_SUB_WIDTH = 16;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef logic [ADD_SUB_WIDTH-1:0] word_t;

endpackage : add_sub_pkg

// File: rtl/add_sub_16b_full_adder.sv
// One-bit full adder cell; sixteen of these form the ripple-carry chain.
// Ports: a, b, cin (operand bits and carry in) -> s (sum bit), co (carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ cin;
    assign co = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/add_sub_16b.sv
// Registered 16-bit two's-complement adder/subtractor for the ALU datapath.
// Ports: clk, rst (async, active-high), in0, in1, sel (0 add, 1 sub) ->
//        sum, cout (carry / not-borrow), and with ADD_SUB_16B_FLAGS_EN
//        also ovf (signed overflow) and zero (result is zero).
// All outputs are registered; latency is one cycle, one op per cycle.
module add_sub_16b
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADD_SUB_16B_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    generate
        if (WIDTH != ADD_SUB_WIDTH) begin : g_width_chk
            $error("add_sub_16b: only WIDTH = 16 is supported");
        end
    endgenerate

    word_t          b;
    word_t          s;
    logic [WIDTH:0] c;

    // Subtraction is in0 + ~in1 + 1: invert B and inject sel as carry-in.
    assign b    = in1 ^ {WIDTH{sel}};
    assign c[0] = (sel == SEL_SUB);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a   (in0[i]),
                .b   (b[i]),
                .cin (c[i]),
                .s   (s[i]),
                .co  (c[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c[WIDTH];
        end
    end

`ifdef ADD_SUB_16B_FLAGS_EN
    logic ovf_d;
    logic zero_d;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_d  = c[WIDTH] ^ c[WIDTH-1];
    assign zero_d = (s == '0);

    // zero resets low even though sum resets to zero; it only reflects
    // results that were actually computed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            ovf  <= ovf_d;
            zero <= zero_d;
        end
    end
`endif

endmodule : add_sub_16b

// File: tb/tb_add_sub_16b.sv
// Self-checking bench for add_sub_16b: directed vectors, random
// back-to-back traffic and a mid-cycle reset, checked via a scoreboard.
module tb_add_sub_16b;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        sel;
    logic [15:0] sum;
    logic        cout;
`ifdef ADD_SUB_16B_FLAGS_EN
    logic        ovf;
    logic        zero;
`endif

    int n_chk;
    int n_fail;
    exp_t exp_q[$];

    add_sub_16b #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .in0  (in0),
        .in1  (in1),
        .sel  (sel),
        .sum  (sum),
        .cout (cout)
`ifdef ADD_SUB_16B_FLAGS_EN
        ,
        .ovf  (ovf),
        .zero (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model from integer arithmetic, not from the adder chain.
    function automatic exp_t model(input logic [15:0] a,
                                   input logic [15:0] bb,
                                   input logic s);
        exp_t e;
        int ua, ub, sa, sb, t;
        ua = int'(a);
        ub = int'(bb);
        sa = int'($signed(a));
        sb = int'($signed(bb));
        if (s) begin
            e.sum  = 16'(ua - ub);
            e.cout = (ua >= ub);
            t      = sa - sb;
        end else begin
            e.sum  = 16'(ua + ub);
            e.cout = (ua + ub) > 65535;
            t      = sa + sb;
        end
        e.ovf  = (t > 32767) || (t < -32768);
        e.zero = (e.sum == 16'h0000);
        return e;
    endfunction

    task automatic drive(input logic [15:0] a,
                         input logic [15:0] bb,
                         input logic s);
        @(negedge clk);
        in0 = a;
        in1 = bb;
        sel = s;
        exp_q.push_back(model(a, bb, s));
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_sum"}, 32'(sum), 32'h0);
        check({tag, "_cout"}, 32'(cout), 32'h0);
`ifdef ADD_SUB_16B_FLAGS_EN
        check({tag, "_ovf"}, 32'(ovf), 32'h0);
        check({tag, "_zero"}, 32'(zero), 32'h0);
`endif
    endtask

    // Scoreboard: each driven op is expected right after the next edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e.sum));
            check("cout", 32'(cout), 32'(e.cout));
`ifdef ADD_SUB_16B_FLAGS_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("zero", 32'(zero), 32'(e.zero));
`endif
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        in0    = 16'h0000;
        in1    = 16'h0000;
        sel    = 1'b0;
        #3;
        check_zeroed("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zeroed("post_rst");

        drive(16'h1975, 16'h0001, 1'b0);
        drive(16'hF975, 16'hF001, 1'b0);
        drive(16'h1975, 16'h0001, 1'b1);
        drive(16'h0000, 16'h0001, 1'b1);
        drive(16'h1234, 16'h1234, 1'b1);
        drive(16'h7FFF, 16'h0001, 1'b0);
        drive(16'h8000, 16'h0001, 1'b1);
        drive(16'hFFFF, 16'h0001, 1'b0);
        drive(16'h0000, 16'h0000, 1'b0);
        drive(16'h8000, 16'h8000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
        end

        drive(16'h7FFF, 16'h0001, 1'b0);
        drive(16'h4000, 16'h0123, 1'b1);
        // Reset between edges: the in-flight op is discarded and outputs
        // clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_zeroed("mid_rst");
        #1;
        rst = 1'b0;
        // First edge after release registers the inputs still applied.
        exp_q.push_back(model(in0, in1, sel));

        drive(16'hABCD, 16'h1111, 1'b1);
        drive(16'h0001, 16'hFFFF, 1'b0);

        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule : tb_add_sub_16b
